// File: rtl/datamem_ctrl_pkg.sv
// datamem_ctrl_pkg: shared FSM states, fault codes and default timeout for the datamem access controller.
package datamem_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic [1:0] FLT_NONE     = 2'd0;
   localparam logic [1:0] FLT_MISALIGN = 2'd1;
   localparam logic [1:0] FLT_CONFLICT = 2'd2;
   localparam logic [1:0] FLT_TIMEOUT  = 2'd3;
   localparam int DEF_TIMEOUT = 15;
endpackage

// File: rtl/datamem_timeout_counter.sv
// datamem_timeout_counter: saturating BUSY-cycle counter flagging the last cycle before timeout.
module datamem_timeout_counter #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);
   localparam int CW = $clog2(LIMIT + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clear_i ? '0 : (enable_i && cnt_q != CW'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   assign expired_o = cnt_q == CW'(LIMIT - 1);
endmodule

// File: rtl/datamem_access_ctrl.sv
// datamem_access_ctrl: sequences datamem-stage loads/stores onto a req/ack memory, stalling the pipeline
// and flagging misaligned, conflicting and timed-out accesses.
module datamem_access_ctrl
   import datamem_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ReadMem,
   input  logic              MemWr,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [DATA_W-1:0] WData,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall,
   output logic [DATA_W-1:0] RData,
   output logic              RDataValid,
   output logic              fault,
   output logic [1:0]        fault_code
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic              we_q, we_d;
   logic [1:0]        code_q, code_d;
   logic              req, misalign, conflict, legal, load, expired;
   assign req      = ReadMem | MemWr;
   assign misalign = |Addr[OFF_W-1:0];
   assign conflict = ReadMem & MemWr;
   assign legal    = !misalign && !conflict;
   assign load     = state_q == IDLE && req && legal;
   datamem_timeout_counter #(.LIMIT(TIMEOUT)) u_tmo (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (load),
      .enable_i (state_q == BUSY),
      .expired_o(expired)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   always_comb
      state_d = state_q == IDLE ? (!req ? IDLE : legal ? BUSY : DONE) :
                state_q == BUSY ? ((mem_ack || expired) ? DONE : BUSY) : IDLE;
   always_comb begin
      addr_d  = load ? Addr : addr_q;
      wdata_d = load ? WData : wdata_q;
      we_d    = load ? MemWr : we_q;
      rdata_d = (state_q == BUSY && mem_ack && !we_q) ? mem_rdata : rdata_q;
      code_d  = (state_q == IDLE && req) ? (misalign ? FLT_MISALIGN : conflict ? FLT_CONFLICT : FLT_NONE) :
                (state_q == BUSY && !mem_ack && expired) ? FLT_TIMEOUT : code_q;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
         code_q  <= FLT_NONE;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
         code_q  <= code_d;
      end
   // Reset gates stall so a held request cannot keep the pipeline frozen while the block is being reset.
   always_comb begin
      mem_req    = state_q == BUSY;
      stall      = !reset && (mem_req || (state_q == IDLE && req));
      RDataValid = state_q == DONE && code_q == FLT_NONE && !we_q;
      fault      = state_q == DONE && code_q != FLT_NONE;
      fault_code = fault ? code_q : FLT_NONE;
   end
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign RData     = rdata_q;
endmodule

// File: tb/tb_datamem_access_ctrl.sv
// tb_datamem_access_ctrl: directed stimulus with queued expectations checked by a negedge monitor.
module tb_datamem_access_ctrl;
   logic        clk = 0, reset = 1;
   logic        ReadMem = 0, MemWr = 0, mem_ack = 0;
   logic [63:0] Addr = 0, WData = 0, mem_rdata = 0;
   logic        mem_req, mem_we, stall, RDataValid, fault;
   logic [63:0] mem_addr, mem_wdata, RData;
   logic [1:0]  fault_code;

   typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata; int len;} req_t;
   typedef struct {logic v; logic f; logic [1:0] c; logic [63:0] d;} done_t;
   req_t  req_q[$];
   done_t done_q[$];
   int    stall_q[$];
   int    total = 0, bad = 0;
   logic [63:0] exp_rdata = 0;

   datamem_access_ctrl dut (
      .clk(clk), .reset(reset), .ReadMem(ReadMem), .MemWr(MemWr), .Addr(Addr), .WData(WData),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .RData(RData),
      .RDataValid(RDataValid), .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;

   task automatic chk(string n, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   task automatic unexp(string n);
      total++;
      bad++;
      $display("FAIL %s: got unexpected event want none", n);
   endtask

   int    req_run = 0, stall_run = 0;
   req_t  cur;
   bit    have_req = 0;
   done_t d;
   always @(negedge clk) begin
      if (mem_req) begin
         if (req_run == 0) begin
            if (req_q.size() == 0) begin
               unexp("mem_req_issue");
               have_req = 0;
            end else begin
               cur = req_q.pop_front();
               have_req = 1;
               chk("mem_we", mem_we, cur.we);
               chk("mem_addr", mem_addr, cur.addr);
               chk("mem_wdata", mem_wdata, cur.wdata);
            end
         end else if (have_req) chk("mem_addr_stable", mem_addr, cur.addr);
         req_run++;
      end else if (req_run != 0) begin
         if (have_req) chk("mem_req_len", 64'(req_run), 64'(cur.len));
         req_run = 0;
      end
      if (stall) stall_run++;
      else if (stall_run != 0) begin
         if (stall_q.size() == 0) unexp("stall_run");
         else chk("stall_len", 64'(stall_run), 64'(stall_q.pop_front()));
         stall_run = 0;
      end
      if (RDataValid || fault) begin
         if (done_q.size() == 0) unexp("done_strobe");
         else begin
            d = done_q.pop_front();
            chk("RDataValid", RDataValid, d.v);
            chk("fault", fault, d.f);
            chk("fault_code", fault_code, d.c);
            chk("RData", RData, d.d);
         end
      end
   end

   // Drives one instruction: request cycle, 'busy' BUSY cycles (ack in the last if 'ack'), then the DONE cycle.
   task automatic access(input logic rd, input logic wr, input logic [63:0] a, input logic [63:0] wd,
                         input int busy, input logic ack, input logic [63:0] rdat, input logic [1:0] code);
      @(posedge clk) #1;
      ReadMem = rd; MemWr = wr; Addr = a; WData = wd;
      if (busy > 0) req_q.push_back('{wr, a, wd, busy});
      stall_q.push_back(busy + 1);
      if (code != 0) done_q.push_back('{1'b0, 1'b1, code, exp_rdata});
      else if (rd) begin
         exp_rdata = rdat;
         done_q.push_back('{1'b1, 1'b0, 2'd0, rdat});
      end
      for (int i = 1; i <= busy; i++) begin
         @(posedge clk) #1;
         mem_ack = ack && i == busy;
         mem_rdata = rdat;
      end
      @(posedge clk) #1;
      mem_ack = 0;
   endtask

   task automatic idle();
      @(posedge clk) #1;
      ReadMem = 0; MemWr = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_RData", RData, 0);
      chk("rst_RDataValid", RDataValid, 0);
      chk("rst_fault", fault, 0);
      chk("rst_fault_code", fault_code, 0);
      @(posedge clk) #1 reset = 0;
      access(1, 0, 64'h10, 0, 3, 1, 64'hDEADBEEF, 0);
      access(0, 1, 64'h20, 64'h55, 1, 1, 0, 0);
      access(1, 0, 64'h13, 0, 0, 0, 0, 1);
      access(1, 1, 64'h08, 0, 0, 0, 0, 2);
      access(1, 1, 64'h03, 0, 0, 0, 0, 1);
      idle();
      access(1, 0, 64'h40, 0, 15, 0, 64'h1111, 3);
      access(1, 0, 64'h48, 0, 15, 1, 64'hCAFEF00D, 0);
      idle();
      access(1, 0, 64'h00, 0, 1, 1, 64'h1234, 0);
      access(1, 0, 64'h08, 0, 1, 1, 64'h5678, 0);
      idle();
      @(posedge clk) #1;
      ReadMem = 1; Addr = 64'h30;
      req_q.push_back('{1'b0, 64'h30, 64'h0, 1});
      stall_q.push_back(2);
      @(posedge clk) #1;
      @(posedge clk) #1;
      reset = 1;
      ReadMem = 0;
      exp_rdata = 0;
      #1;
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      chk("mid_rst_RData", RData, 0);
      chk("mid_rst_mem_we", mem_we, 0);
      @(posedge clk) #1 reset = 0;
      @(posedge clk) #1;
      mem_ack = 1; mem_rdata = 64'hBAD;
      @(posedge clk) #1 mem_ack = 0;
      chk("late_ack_RData", RData, 0);
      access(1, 0, 64'h18, 0, 2, 1, 64'hA5, 0);
      idle();
      repeat (3) @(posedge clk);
      #1;
      chk("final_RData", RData, exp_rdata);
      chk("req_q_empty", 64'(req_q.size()), 0);
      chk("done_q_empty", 64'(done_q.size()), 0);
      chk("stall_q_empty", 64'(stall_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
